// File: rtl/data_cache_wt.sv
// Direct-mapped, write-through / no-write-allocate data cache with byte-granular
// line-crossing loads and stores, word-at-a-time refill and saturating hit/miss counters.
`ifndef D_CACHE_DEFS
`define D_CACHE_DEFS
`define ONE_BYTE          3'b000
`define TWO_BYTE          3'b001
`define FOUR_BYTE         3'b010
`define D_CACHE_NOP       2'b00
`define D_CACHE_LOAD      2'b01
`define D_CACHE_STORE     2'b10
`define D_CACHE_RESTING   2'b00
`define D_CACHE_WORKING   2'b01
`define D_CACHE_STALL     2'b10
`define L_S_FINISHED      2'b11
`define MEM_RESTING       2'b00
`define MEM_DATA_FINISHED 2'b01
`define MEM_NOP           2'b00
`define MEM_READ          2'b01
`define MEM_WRITE         2'b10
`endif

module data_cache_wt #(
  parameter int ADDR_WIDTH  = 17,
  parameter int DATA_LEN    = 32,
  parameter int LINE_WORDS  = 2,
  parameter int CACHE_LINES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [2:0]            data_type,
  input  logic [DATA_LEN-1:0]   cache_written_data,
  input  logic [1:0]            cache_vis_signal,
  output logic [DATA_LEN-1:0]   data,
  output logic [1:0]            d_cache_vis_status,
  input  logic [DATA_LEN-1:0]   mem_data,
  input  logic [1:0]            mem_status,
  output logic [DATA_LEN-1:0]   mem_written_data,
  output logic [2:0]            written_data_type,
  output logic [ADDR_WIDTH-1:0] mem_vis_addr,
  output logic [1:0]            mem_vis_signal,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
);
  localparam int LB     = $clog2(LINE_WORDS) + 2;
  localparam int IB     = $clog2(CACHE_LINES);
  localparam int CB     = LB + IB;
  localparam int TAG_W  = ADDR_WIDTH - CB;
  localparam int LN_W   = ADDR_WIDTH - LB;
  localparam int NBYTES = 1 << CB;
  localparam int WB     = (LB > 2) ? LB - 2 : 1;

  typedef enum logic [2:0] {IDLE, FILL_REQ, FILL_WAIT, STORE_REQ, STORE_WAIT, DONE} state_t;

  // Bytes are stored flat so that consecutive addresses wrap naturally into the next line.
  logic [7:0]             r_bytes [NBYTES];
  logic [CACHE_LINES-1:0] r_valid;
  logic [TAG_W-1:0]       r_tag [CACHE_LINES];

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_type;
  logic [DATA_LEN-1:0]   r_wdata;
  logic                  r_fill_line;
  logic                  r_need1;
  logic [WB-1:0]         r_word;
  logic [DATA_LEN-1:0]   r_data;
  logic [1:0]            r_status;
  logic [1:0]            r_mem_sig;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_LEN-1:0]   r_mem_wdata;
  logic [2:0]            r_mem_type;
  logic [31:0]           r_hit;
  logic [31:0]           r_miss;

  function automatic logic [2:0] size_of(input logic [2:0] t);
    case (t)
      `ONE_BYTE: size_of = 3'd1;
      `TWO_BYTE: size_of = 3'd2;
      default:   size_of = 3'd4;
    endcase
  endfunction

  function automatic logic [DATA_LEN-1:0] sext(input logic [31:0] w, input logic [2:0] t);
    case (t)
      `ONE_BYTE: sext = DATA_LEN'($signed(w[7:0]));
      `TWO_BYTE: sext = DATA_LEN'($signed(w[15:0]));
      default:   sext = DATA_LEN'($signed(w));
    endcase
  endfunction

  // Request-side hit check: line 1 is the line holding the last byte of the access.
  logic [LB:0]   w_req_last;
  logic          w_req_cross;
  logic [LN_W-1:0] w_req_line0, w_req_line1;
  logic          w_hit0, w_hit1, w_hit;
  logic [31:0]   w_req_word;

  assign w_req_last  = {1'b0, data_addr[LB-1:0]} + (LB+1)'(size_of(data_type) - 3'd1);
  assign w_req_cross = (w_req_last >= (LB+1)'(1 << LB));
  assign w_req_line0 = data_addr[ADDR_WIDTH-1:LB];
  assign w_req_line1 = w_req_line0 + LN_W'(w_req_cross);
  assign w_hit0 = r_valid[w_req_line0[IB-1:0]] && (r_tag[w_req_line0[IB-1:0]] == w_req_line0[LN_W-1:IB]);
  assign w_hit1 = r_valid[w_req_line1[IB-1:0]] && (r_tag[w_req_line1[IB-1:0]] == w_req_line1[LN_W-1:IB]);
  assign w_hit  = w_hit0 && (!w_req_cross || w_hit1);

  // Latched-request geometry drives refill addressing and the final assembly.
  logic [LB:0]           w_lat_last;
  logic                  w_lat_cross;
  logic [LN_W-1:0]       w_lat_line0, w_lat_line1, w_fill_line;
  logic [ADDR_WIDTH-1:0] w_fill_addr;
  logic [31:0]           w_lat_word;
  logic [ADDR_WIDTH-1:0] w_st_addr [4];
  logic [3:0]            w_st_hit;

  assign w_lat_last  = {1'b0, r_addr[LB-1:0]} + (LB+1)'(size_of(r_type) - 3'd1);
  assign w_lat_cross = (w_lat_last >= (LB+1)'(1 << LB));
  assign w_lat_line0 = r_addr[ADDR_WIDTH-1:LB];
  assign w_lat_line1 = w_lat_line0 + LN_W'(w_lat_cross);
  assign w_fill_line = r_fill_line ? w_lat_line1 : w_lat_line0;
  assign w_fill_addr = {w_fill_line, LB'(0)} + (ADDR_WIDTH'(r_word) << 2);

  for (genvar gi = 0; gi < 4; gi++) begin : g_bytes
    assign w_req_word[gi*8 +: 8] = r_bytes[data_addr[CB-1:0] + CB'(gi)];
    assign w_lat_word[gi*8 +: 8] = r_bytes[r_addr[CB-1:0] + CB'(gi)];
    assign w_st_addr[gi] = r_addr + ADDR_WIDTH'(gi);
    assign w_st_hit[gi]  = (3'(gi) < size_of(r_type))
                           && r_valid[w_st_addr[gi][CB-1:LB]]
                           && (r_tag[w_st_addr[gi][CB-1:LB]] == w_st_addr[gi][ADDR_WIDTH-1:CB]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_valid     <= '0;
      r_addr      <= '0;
      r_type      <= '0;
      r_wdata     <= '0;
      r_fill_line <= 1'b0;
      r_need1     <= 1'b0;
      r_word      <= '0;
      r_data      <= '0;
      r_status    <= `D_CACHE_RESTING;
      r_mem_sig   <= `MEM_NOP;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_type  <= '0;
      r_hit       <= '0;
      r_miss      <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_status <= `D_CACHE_RESTING;
          if (cache_vis_signal == `D_CACHE_LOAD || cache_vis_signal == `D_CACHE_STORE) begin
            r_addr  <= data_addr;
            r_type  <= data_type;
            r_wdata <= cache_written_data;
            if (cache_vis_signal == `D_CACHE_STORE) begin
              r_status <= `D_CACHE_WORKING;
              r_state  <= STORE_REQ;
            end else if (w_hit) begin
              r_data   <= sext(w_req_word, data_type);
              r_status <= `L_S_FINISHED;
              r_hit    <= (r_hit == 32'hFFFF_FFFF) ? r_hit : r_hit + 32'd1;
            end else begin
              // Skip straight to line 1 when only the upper line is missing.
              r_fill_line <= w_hit0;
              r_need1     <= w_req_cross && !w_hit1;
              r_word      <= '0;
              r_status    <= `D_CACHE_WORKING;
              r_miss      <= (r_miss == 32'hFFFF_FFFF) ? r_miss : r_miss + 32'd1;
              r_state     <= FILL_REQ;
            end
          end
        end
        FILL_REQ: begin
          if (mem_status == `MEM_RESTING) begin
            r_mem_sig  <= `MEM_READ;
            r_mem_addr <= w_fill_addr;
            r_status   <= `D_CACHE_WORKING;
            r_state    <= FILL_WAIT;
          end else begin
            r_status <= `D_CACHE_STALL;
          end
        end
        FILL_WAIT: begin
          if (mem_status == `MEM_DATA_FINISHED) begin
            for (int k = 0; k < 4; k++)
              r_bytes[w_fill_addr[CB-1:0] + CB'(k)] <= mem_data[8*k +: 8];
            r_mem_sig <= `MEM_NOP;
            r_status  <= `D_CACHE_WORKING;
            if (r_word == WB'(LINE_WORDS - 1)) begin
              r_valid[w_fill_line[IB-1:0]] <= 1'b1;
              r_tag[w_fill_line[IB-1:0]]   <= w_fill_line[LN_W-1:IB];
              r_word <= '0;
              if (!r_fill_line && r_need1) begin
                r_fill_line <= 1'b1;
                r_state     <= FILL_REQ;
              end else begin
                r_state <= DONE;
              end
            end else begin
              r_word  <= r_word + WB'(1);
              r_state <= FILL_REQ;
            end
          end else begin
            r_status <= `D_CACHE_STALL;
          end
        end
        DONE: begin
          r_data   <= sext(w_lat_word, r_type);
          r_status <= `L_S_FINISHED;
          r_state  <= IDLE;
        end
        STORE_REQ: begin
          if (mem_status == `MEM_RESTING) begin
            r_mem_sig   <= `MEM_WRITE;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
            r_mem_type  <= r_type;
            r_status    <= `D_CACHE_WORKING;
            for (int k = 0; k < 4; k++)
              if (w_st_hit[k]) r_bytes[w_st_addr[k][CB-1:0]] <= r_wdata[8*k +: 8];
            r_state <= STORE_WAIT;
          end else begin
            r_status <= `D_CACHE_STALL;
          end
        end
        STORE_WAIT: begin
          if (mem_status == `MEM_DATA_FINISHED) begin
            r_mem_sig <= `MEM_NOP;
            r_status  <= `L_S_FINISHED;
            r_state   <= IDLE;
          end else begin
            r_status <= `D_CACHE_STALL;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data               = r_data;
  assign d_cache_vis_status = r_status;
  assign mem_vis_signal     = r_mem_sig;
  assign mem_vis_addr       = r_mem_addr;
  assign mem_written_data   = r_mem_wdata;
  assign written_data_type  = r_mem_type;
  assign hit_count          = r_hit;
  assign miss_count         = r_miss;
endmodule

// File: tb/tb_data_cache_wt.sv
// Directed bench for data_cache_wt: a byte-array memory responder plus one task per scenario.
`ifndef D_CACHE_DEFS
`define D_CACHE_DEFS
`define ONE_BYTE          3'b000
`define TWO_BYTE          3'b001
`define FOUR_BYTE         3'b010
`define D_CACHE_NOP       2'b00
`define D_CACHE_LOAD      2'b01
`define D_CACHE_STORE     2'b10
`define D_CACHE_RESTING   2'b00
`define D_CACHE_WORKING   2'b01
`define D_CACHE_STALL     2'b10
`define L_S_FINISHED      2'b11
`define MEM_RESTING       2'b00
`define MEM_DATA_FINISHED 2'b01
`define MEM_NOP           2'b00
`define MEM_READ          2'b01
`define MEM_WRITE         2'b10
`endif

module tb_data_cache_wt;
  localparam int AW = 17;
  localparam int DL = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] data_addr = '0;
  logic [2:0]    data_type = '0;
  logic [DL-1:0] cache_written_data = '0;
  logic [1:0]    cache_vis_signal = `D_CACHE_NOP;
  logic [DL-1:0] data;
  logic [1:0]    d_cache_vis_status;
  logic [DL-1:0] mem_data = '0;
  logic [1:0]    mem_status = `MEM_RESTING;
  logic [DL-1:0] mem_written_data;
  logic [2:0]    written_data_type;
  logic [AW-1:0] mem_vis_addr;
  logic [1:0]    mem_vis_signal;
  logic [31:0]   hit_count, miss_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  data_cache_wt #(.ADDR_WIDTH(AW), .DATA_LEN(DL), .LINE_WORDS(2), .CACHE_LINES(16)) dut (
    .clk(clk), .rst(rst), .data_addr(data_addr), .data_type(data_type),
    .cache_written_data(cache_written_data), .cache_vis_signal(cache_vis_signal),
    .data(data), .d_cache_vis_status(d_cache_vis_status), .mem_data(mem_data),
    .mem_status(mem_status), .mem_written_data(mem_written_data),
    .written_data_type(written_data_type), .mem_vis_addr(mem_vis_addr),
    .mem_vis_signal(mem_vis_signal), .hit_count(hit_count), .miss_count(miss_count)
  );

  // Memory: byte array, answers each new request two negedges later with a one-cycle FINISHED.
  logic [7:0]    mem_model [256];
  logic [AW-1:0] rd_log [$];
  logic [AW-1:0] wr_addr_log [$];
  logic [DL-1:0] wr_data_log [$];
  logic [2:0]    wr_type_log [$];
  logic [1:0]    prev_sig = `MEM_NOP;
  logic [1:0]    req_kind = `MEM_NOP;
  logic [7:0]    req_base = '0;
  logic [DL-1:0] req_wdata = '0;
  logic [2:0]    req_type = '0;
  int            busy_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      mem_status = `MEM_RESTING;
      busy_cnt = 0;
      prev_sig = `MEM_NOP;
    end else begin
      if (mem_status == `MEM_DATA_FINISHED) mem_status = `MEM_RESTING;
      if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) begin
          if (req_kind == `MEM_READ) begin
            mem_data = {mem_model[req_base + 8'd3], mem_model[req_base + 8'd2],
                        mem_model[req_base + 8'd1], mem_model[req_base]};
          end else begin
            for (int k = 0; k < 4; k++)
              if (k == 0 || (k == 1 && req_type != `ONE_BYTE) || (k > 1 && req_type == `FOUR_BYTE))
                mem_model[req_base + 8'(k)] = req_wdata[8*k +: 8];
          end
          mem_status = `MEM_DATA_FINISHED;
        end
      end
      if (mem_vis_signal != `MEM_NOP && prev_sig == `MEM_NOP) begin
        busy_cnt  = 2;
        req_kind  = mem_vis_signal;
        req_base  = mem_vis_addr[7:0];
        req_wdata = mem_written_data;
        req_type  = written_data_type;
        if (mem_vis_signal == `MEM_READ) rd_log.push_back(mem_vis_addr);
        else begin
          wr_addr_log.push_back(mem_vis_addr);
          wr_data_log.push_back(mem_written_data);
          wr_type_log.push_back(written_data_type);
        end
      end
      prev_sig = mem_vis_signal;
    end
  end

  // Pulse one request, then wait (bounded) for L_S_FINISHED; cyc=1 means a one-cycle hit.
  task automatic do_req(input logic [1:0] sig, input logic [2:0] t, input logic [AW-1:0] a,
                        input logic [DL-1:0] wd, output int cyc);
    @(negedge clk);
    cache_vis_signal = sig;
    data_type = t;
    data_addr = a;
    cache_written_data = wd;
    @(negedge clk);
    cache_vis_signal = `D_CACHE_NOP;
    cyc = 1;
    while (d_cache_vis_status != `L_S_FINISHED && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    $display("txn sig=%0d type=%0d addr=0x%0h wd=0x%0h -> data=0x%08h cycles=%0d", sig, t, a, wd, data, cyc);
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    total++;
    if (d_cache_vis_status !== `D_CACHE_RESTING || mem_vis_signal !== `MEM_NOP) begin
      bad++; $display("FAIL reset_status: status=%0d sig=%0d required 0/0", d_cache_vis_status, mem_vis_signal);
    end
    total++;
    if (data !== 32'h0 || mem_vis_addr !== '0 || mem_written_data !== '0 || written_data_type !== 3'd0) begin
      bad++; $display("FAIL reset_regs: data=0x%0h addr=0x%0h wdata=0x%0h type=%0d required all 0", data, mem_vis_addr, mem_written_data, written_data_type);
    end
    total++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      bad++; $display("FAIL reset_counters: hit=%0d miss=%0d required 0/0", hit_count, miss_count);
    end
  endtask

  task automatic test_fill_and_hit;
    int cyc;
    rd_log.delete();
    do_req(`D_CACHE_LOAD, `FOUR_BYTE, 17'h10, '0, cyc);
    total++;
    if (d_cache_vis_status !== `L_S_FINISHED || data !== 32'h80FF0102) begin
      bad++; $display("FAIL fill_data: status=%0d data=0x%08h required 3/0x80ff0102", d_cache_vis_status, data);
    end
    total++;
    if (rd_log.size() != 2 || rd_log[0] !== 17'h10 || rd_log[1] !== 17'h14) begin
      bad++; $display("FAIL fill_reads: count=%0d first=0x%0h required 2 reads 0x10,0x14", rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 17'h0);
    end
    total++;
    if (miss_count !== 32'd1 || hit_count !== 32'd0) begin
      bad++; $display("FAIL fill_counts: hit=%0d miss=%0d required 0/1", hit_count, miss_count);
    end
    do_req(`D_CACHE_LOAD, `FOUR_BYTE, 17'h10, '0, cyc);
    total++;
    if (cyc != 1 || data !== 32'h80FF0102 || rd_log.size() != 2) begin
      bad++; $display("FAIL hit_latency: cycles=%0d data=0x%08h reads=%0d required 1/0x80ff0102/2", cyc, data, rd_log.size());
    end
    total++;
    if (hit_count !== 32'd1) begin
      bad++; $display("FAIL hit_count: hit=%0d required 1", hit_count);
    end
    @(negedge clk);
    total++;
    if (d_cache_vis_status !== `D_CACHE_RESTING) begin
      bad++; $display("FAIL back_to_rest: status=%0d required 0", d_cache_vis_status);
    end
  endtask

  task automatic test_byte_loads;
    int cyc;
    do_req(`D_CACHE_LOAD, `ONE_BYTE, 17'h13, '0, cyc);
    total++;
    if (cyc != 1 || data !== 32'hFFFFFF80) begin
      bad++; $display("FAIL byte_sext: cycles=%0d data=0x%08h required 1/0xffffff80", cyc, data);
    end
    do_req(`D_CACHE_LOAD, `TWO_BYTE, 17'h12, '0, cyc);
    total++;
    if (cyc != 1 || data !== 32'hFFFF80FF) begin
      bad++; $display("FAIL half_sext: cycles=%0d data=0x%08h required 1/0xffff80ff", cyc, data);
    end
    do_req(`D_CACHE_LOAD, `TWO_BYTE, 17'h10, '0, cyc);
    total++;
    if (data !== 32'h00000102) begin
      bad++; $display("FAIL half_pos: data=0x%08h required 0x00000102", data);
    end
  endtask

  task automatic test_cross_line;
    int cyc;
    rd_log.delete();
    do_req(`D_CACHE_LOAD, `FOUR_BYTE, 17'h1E, '0, cyc);
    total++;
    if (d_cache_vis_status !== `L_S_FINISHED || data !== 32'h7B7A4544) begin
      bad++; $display("FAIL cross_data: status=%0d data=0x%08h required 3/0x7b7a4544", d_cache_vis_status, data);
    end
    total++;
    if (rd_log.size() != 4 || rd_log[0] !== 17'h18 || rd_log[1] !== 17'h1C || rd_log[2] !== 17'h20 || rd_log[3] !== 17'h24) begin
      bad++; $display("FAIL cross_reads: count=%0d first=0x%0h required 4 reads 0x18,0x1c,0x20,0x24", rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 17'h0);
    end
    total++;
    if (miss_count !== 32'd2) begin
      bad++; $display("FAIL cross_miss: miss=%0d required 2", miss_count);
    end
    do_req(`D_CACHE_LOAD, `FOUR_BYTE, 17'h1E, '0, cyc);
    total++;
    if (cyc != 1 || data !== 32'h7B7A4544 || rd_log.size() != 4) begin
      bad++; $display("FAIL cross_hit: cycles=%0d data=0x%08h reads=%0d required 1/0x7b7a4544/4", cyc, data, rd_log.size());
    end
  endtask

  task automatic test_store_hit;
    int cyc;
    logic [31:0] hits_before;
    wr_addr_log.delete(); wr_data_log.delete(); wr_type_log.delete(); rd_log.delete();
    do_req(`D_CACHE_STORE, `TWO_BYTE, 17'h10, 32'h00001234, cyc);
    total++;
    if (d_cache_vis_status !== `L_S_FINISHED || wr_addr_log.size() != 1 || rd_log.size() != 0) begin
      bad++; $display("FAIL store_issue: status=%0d writes=%0d reads=%0d required 3/1/0", d_cache_vis_status, wr_addr_log.size(), rd_log.size());
    end else begin
      total++;
      if (wr_addr_log[0] !== 17'h10 || wr_data_log[0] !== 32'h00001234 || wr_type_log[0] !== `TWO_BYTE) begin
        bad++; $display("FAIL store_fields: addr=0x%0h data=0x%0h type=%0d required 0x10/0x1234/1", wr_addr_log[0], wr_data_log[0], wr_type_log[0]);
      end
    end
    hits_before = hit_count;
    do_req(`D_CACHE_LOAD, `TWO_BYTE, 17'h10, '0, cyc);
    total++;
    if (cyc != 1 || data !== 32'h00001234 || hit_count !== hits_before + 32'd1) begin
      bad++; $display("FAIL store_hit_load: cycles=%0d data=0x%08h hit=%0d required 1/0x00001234/%0d", cyc, data, hit_count, hits_before + 32'd1);
    end
    do_req(`D_CACHE_LOAD, `FOUR_BYTE, 17'h10, '0, cyc);
    total++;
    if (cyc != 1 || data !== 32'h80FF1234) begin
      bad++; $display("FAIL store_merge: cycles=%0d data=0x%08h required 1/0x80ff1234", cyc, data);
    end
  endtask

  task automatic test_store_cold;
    int cyc;
    wr_addr_log.delete(); rd_log.delete();
    do_req(`D_CACHE_STORE, `ONE_BYTE, 17'h40, 32'h000000AB, cyc);
    total++;
    if (d_cache_vis_status !== `L_S_FINISHED || wr_addr_log.size() != 1 || rd_log.size() != 0) begin
      bad++; $display("FAIL cold_store: status=%0d writes=%0d reads=%0d required 3/1/0", d_cache_vis_status, wr_addr_log.size(), rd_log.size());
    end
    do_req(`D_CACHE_LOAD, `ONE_BYTE, 17'h40, '0, cyc);
    total++;
    if (miss_count !== 32'd3 || rd_log.size() != 2 || data !== 32'hFFFFFFAB) begin
      bad++; $display("FAIL cold_reload: miss=%0d reads=%0d data=0x%08h required 3/2/0xffffffab", miss_count, rd_log.size(), data);
    end
  endtask

  task automatic test_reset_mid_fill;
    int cyc;
    int waited;
    @(negedge clk);
    cache_vis_signal = `D_CACHE_LOAD; data_type = `FOUR_BYTE; data_addr = 17'h60;
    @(negedge clk);
    cache_vis_signal = `D_CACHE_NOP;
    waited = 0;
    while (mem_vis_signal != `MEM_READ && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (mem_vis_signal !== `MEM_READ) begin
      bad++; $display("FAIL rst_fill_reach: sig=%0d required 1 within 50 cycles", mem_vis_signal);
    end
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    total++;
    if (d_cache_vis_status !== `D_CACHE_RESTING || mem_vis_signal !== `MEM_NOP || hit_count !== 32'd0 || miss_count !== 32'd0) begin
      bad++; $display("FAIL rst_fill_state: status=%0d sig=%0d hit=%0d miss=%0d required 0/0/0/0", d_cache_vis_status, mem_vis_signal, hit_count, miss_count);
    end
    rd_log.delete();
    do_req(`D_CACHE_LOAD, `FOUR_BYTE, 17'h60, '0, cyc);
    total++;
    if (miss_count !== 32'd1 || rd_log.size() != 2 || data !== 32'h39383B3A) begin
      bad++; $display("FAIL rst_fill_reload: miss=%0d reads=%0d data=0x%08h required 1/2/0x39383b3a", miss_count, rd_log.size(), data);
    end
    do_req(`D_CACHE_LOAD, `FOUR_BYTE, 17'h10, '0, cyc);
    total++;
    if (cyc == 1 || miss_count !== 32'd2) begin
      bad++; $display("FAIL rst_cleared_valid: cycles=%0d miss=%0d required >1/2", cyc, miss_count);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 8'(i) ^ 8'h5A;
    mem_model[8'h10] = 8'h02;
    mem_model[8'h11] = 8'h01;
    mem_model[8'h12] = 8'hFF;
    mem_model[8'h13] = 8'h80;
    test_reset();
    test_fill_and_hit();
    test_byte_loads();
    test_cross_line();
    test_store_hit();
    test_store_cold();
    test_reset_mid_fill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
